// File: rtl/game_step_sequencer.sv
// -----------------------------------------------------------------------------
// game_step_sequencer
//
// Game-flow controller for the 16x16 falling-block playfield. It owns the
// gravity timebase, a single-entry key command register, the score and the
// game-over flag. Each move goes through the external collision checker.
// After a failed down move the piece is locked, the full rows are scanned and
// shifted out, and then a new piece is spawned.
//
// Ports
//   clk, resetn          system clock, asynchronous active-low reset
//   key_valid, key_code  one-cycle PS/2 make code (75 rot, 6B left, 74 right,
//                        72 soft drop)
//   chk_req, chk_op      collision-check request and op (00 down, 01 left,
//                        10 right, 11 rotate)
//   chk_ack, chk_ok      one-cycle check completion and verdict
//   commit               one-cycle pulse: apply the checked move
//   lock                 one-cycle pulse: write the active piece into the board
//   row_sel, row_full    row under scan and its combinational "all ones" flag
//   shift_req, shift_row request to delete shift_row; shift_done completes it
//   spawn, top_occupied  new-piece pulse and spawn-area occupancy
//   score, game_over     rows cleared (saturating at 99), sticky end flag
//   state_dbg            current FSM state, for debug
//
// Handshakes: chk_req rises on the first CHECK cycle and stays high, with
// chk_op stable, until the cycle in which chk_ack is sampled high. shift_req
// likewise stays high, with shift_row stable, until shift_done is sampled.
// Both requests are registers, so an asynchronous reset drops them at once.
// -----------------------------------------------------------------------------
module game_step_sequencer #(
    parameter int TICK_SLOW     = 12000000,
    parameter int TICK_FAST     = 7000000,
    parameter int SPEEDUP_SCORE = 3,
    parameter int ROWS          = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       chk_req,
    output logic [1:0] chk_op,
    input  logic       chk_ack,
    input  logic       chk_ok,
    output logic       commit,
    output logic       lock,
    output logic [3:0] row_sel,
    input  logic       row_full,
    output logic       shift_req,
    output logic [3:0] shift_row,
    input  logic       shift_done,
    output logic       spawn,
    input  logic       top_occupied,
    output logic [7:0] score,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    localparam int TICK_MAX = (TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST;
    localparam int TW = $clog2(TICK_MAX + 1);
    localparam logic [TW-1:0] LAST_SLOW = TW'(TICK_SLOW - 1);
    localparam logic [TW-1:0] LAST_FAST = TW'(TICK_FAST - 1);
    localparam logic [3:0]    LAST_ROW  = 4'(ROWS - 1);

    typedef enum logic [2:0] {
        S_SPAWN = 3'd0,
        S_WAIT  = 3'd1,
        S_CHECK = 3'd2,
        S_LOCK  = 3'd3,
        S_SCAN  = 3'd4,
        S_SHIFT = 3'd5,
        S_OVER  = 3'd6
    } state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic          grav_pend;
    logic          key_pend;
    logic [1:0]    key_op;

    logic          key_known;
    logic [1:0]    key_dec;
    logic [TW-1:0] tick_last;
    logic          tick_wrap;
    logic          do_spawn;

    assign state_dbg = state;

    always_comb begin
        key_known = 1'b0;
        key_dec   = 2'b00;
        case (key_code)
            8'h75: begin key_known = 1'b1; key_dec = 2'b11; end
            8'h6B: begin key_known = 1'b1; key_dec = 2'b01; end
            8'h74: begin key_known = 1'b1; key_dec = 2'b10; end
            8'h72: begin key_known = 1'b1; key_dec = 2'b00; end
            default: ;
        endcase
    end

    // ">=" rather than "==" so a period drop while the count is already past
    // the new last value still wraps on the next cycle.
    assign tick_last = (score >= 8'(SPEEDUP_SCORE)) ? LAST_FAST : LAST_SLOW;
    assign tick_wrap = (tick >= tick_last);
    assign do_spawn  = (state == S_SPAWN) && !top_occupied;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_SPAWN;
            tick      <= '0;
            grav_pend <= 1'b0;
            key_pend  <= 1'b0;
            key_op    <= 2'b00;
            chk_req   <= 1'b0;
            chk_op    <= 2'b00;
            commit    <= 1'b0;
            lock      <= 1'b0;
            row_sel   <= LAST_ROW;
            shift_req <= 1'b0;
            shift_row <= 4'd0;
            spawn     <= 1'b0;
            score     <= 8'd0;
            game_over <= 1'b0;
        end else begin
            commit <= 1'b0;
            lock   <= 1'b0;
            spawn  <= 1'b0;

            case (state)
                S_SPAWN: begin
                    if (top_occupied) begin
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else begin
                        spawn <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Gravity wins a tie; the key stays pending for later.
                    if (grav_pend) begin
                        grav_pend <= 1'b0;
                        chk_op    <= 2'b00;
                        chk_req   <= 1'b1;
                        state     <= S_CHECK;
                    end else if (key_pend) begin
                        key_pend <= 1'b0;
                        chk_op   <= key_op;
                        chk_req  <= 1'b1;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_ack) begin
                        chk_req <= 1'b0;
                        if (chk_ok) begin
                            commit <= 1'b1;
                            state  <= S_WAIT;
                        end else if (chk_op == 2'b00) begin
                            lock  <= 1'b1;
                            state <= S_LOCK;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_LOCK: begin
                    row_sel <= LAST_ROW;
                    state   <= S_SCAN;
                end
                S_SCAN: begin
                    // Row 0 is never scanned: the spawn area cannot be full.
                    if (row_full) begin
                        shift_req <= 1'b1;
                        shift_row <= row_sel;
                        state     <= S_SHIFT;
                    end else if (row_sel > 4'd1) begin
                        row_sel <= row_sel - 4'd1;
                    end else begin
                        state <= S_SPAWN;
                    end
                end
                S_SHIFT: begin
                    // Rescan the same row: the rows above have moved into it.
                    if (shift_done) begin
                        shift_req <= 1'b0;
                        if (score < 8'd99) score <= score + 8'd1;
                        state <= S_SCAN;
                    end
                end
                S_OVER: state <= S_OVER;
                default: state <= S_SPAWN;
            endcase

            // A wrap on the same cycle that WAIT consumes grav_pend is a new
            // tick, so this update comes after the case statement.
            if (do_spawn) begin
                tick <= '0;
            end else if (state != S_OVER) begin
                if (tick_wrap) begin
                    tick      <= '0;
                    grav_pend <= 1'b1;
                end else begin
                    tick <= tick + TW'(1);
                end
            end

            // A newly arriving key overrides both an older pending key and
            // the consumption of that key in WAIT.
            if (key_valid && key_known && (state != S_OVER)) begin
                key_pend <= 1'b1;
                key_op   <= key_dec;
            end
        end
    end

endmodule

// File: tb/tb_game_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_step_sequencer
//
// Directed bench for game_step_sequencer with short gravity periods
// (slow 8, fast 4, speed-up at score 3). The bench drives the checker,
// board-row and shift handshakes itself. A small row-occupancy mask stands
// in for the board and supplies row_full.
// -----------------------------------------------------------------------------
module tb_game_step_sequencer;

    localparam logic [2:0] ST_SPAWN = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_LOCK  = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd6;

    logic       clk = 1'b0;
    logic       resetn;
    logic       key_valid;
    logic [7:0] key_code;
    logic       chk_req;
    logic [1:0] chk_op;
    logic       chk_ack;
    logic       chk_ok;
    logic       commit;
    logic       lock;
    logic [3:0] row_sel;
    logic       row_full;
    logic       shift_req;
    logic [3:0] shift_row;
    logic       shift_done;
    logic       spawn;
    logic       top_occupied;
    logic [7:0] score;
    logic       game_over;
    logic [2:0] state_dbg;

    logic [15:0] full_mask;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign row_full = full_mask[row_sel];

    game_step_sequencer #(
        .TICK_SLOW(8), .TICK_FAST(4), .SPEEDUP_SCORE(3), .ROWS(16)
    ) dut (
        .clk(clk), .resetn(resetn),
        .key_valid(key_valid), .key_code(key_code),
        .chk_req(chk_req), .chk_op(chk_op), .chk_ack(chk_ack), .chk_ok(chk_ok),
        .commit(commit), .lock(lock),
        .row_sel(row_sel), .row_full(row_full),
        .shift_req(shift_req), .shift_row(shift_row), .shift_done(shift_done),
        .spawn(spawn), .top_occupied(top_occupied),
        .score(score), .game_over(game_over), .state_dbg(state_dbg)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        key_valid    = 1'b0;
        key_code     = 8'h00;
        chk_ack      = 1'b0;
        chk_ok       = 1'b0;
        shift_done   = 1'b0;
        top_occupied = 1'b0;
        full_mask    = 16'h0000;
    endtask

    // Leaves the bench just after the first edge out of reset (spawn edge).
    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic ack(input logic ok);
        chk_ack = 1'b1;
        chk_ok  = ok;
        step();
        chk_ack = 1'b0;
        chk_ok  = 1'b0;
    endtask

    task automatic wait_req(input int budget, output int n);
        n = 0;
        while (chk_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic wait_spawn(input int budget, output int n);
        n = 0;
        while (spawn !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        step();
        step();
        checks++;
        if ({chk_req, commit, lock, shift_req, spawn, game_over} !== 6'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b expected 000000",
                     {chk_req, commit, lock, shift_req, spawn, game_over});
        end
        checks++;
        if (row_sel !== 4'd15 || score !== 8'd0 || chk_op !== 2'b00) begin
            errors++;
            $display("FAIL reset_regs row_sel %0d score %0d op %0d expected 15 0 0",
                     row_sel, score, chk_op);
        end
        checks++;
        if (state_dbg !== ST_SPAWN) begin
            errors++;
            $display("FAIL reset_state got %0d expected %0d", state_dbg, ST_SPAWN);
        end
        resetn = 1'b1;
        step();
        checks++;
        if (spawn !== 1'b1 || state_dbg !== ST_WAIT) begin
            errors++;
            $display("FAIL first_spawn spawn %b state %0d expected 1 %0d",
                     spawn, state_dbg, ST_WAIT);
        end
        step();
        checks++;
        if (spawn !== 1'b0) begin
            errors++;
            $display("FAIL spawn_pulse_width got %b expected 0", spawn);
        end
    endtask

    task automatic test_gravity();
        int n;
        int t[3];
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wait_req(20, n);
            t[k] = cyc;
            checks++;
            if (chk_req !== 1'b1 || chk_op !== 2'b00) begin
                errors++;
                $display("FAIL grav_req%0d req %b op %0d expected 1 0", k, chk_req, chk_op);
            end
            if (k == 0) begin
                checks++;
                if (n !== 9) begin
                    errors++;
                    $display("FAIL grav_first_delay got %0d expected 9", n);
                end
            end
            ack(1'b1);
            checks++;
            if (commit !== 1'b1 || chk_req !== 1'b0) begin
                errors++;
                $display("FAIL grav_commit%0d commit %b req %b expected 1 0", k, commit, chk_req);
            end
            step();
            checks++;
            if (commit !== 1'b0) begin
                errors++;
                $display("FAIL grav_commit_width%0d got %b expected 0", k, commit);
            end
        end
        checks++;
        if (t[1] - t[0] !== 8 || t[2] - t[1] !== 8) begin
            errors++;
            $display("FAIL grav_spacing got %0d %0d expected 8 8", t[1] - t[0], t[2] - t[1]);
        end
    endtask

    task automatic test_unknown_and_soft_drop();
        do_reset();
        key_valid = 1'b1;
        key_code  = 8'h1C;
        step();
        key_valid = 1'b0;
        step();
        step();
        checks++;
        if (chk_req !== 1'b0) begin
            errors++;
            $display("FAIL unknown_key_ignored req %b expected 0", chk_req);
        end
        key_valid = 1'b1;
        key_code  = 8'h72;
        step();
        key_valid = 1'b0;
        step();
        checks++;
        if (chk_req !== 1'b1 || chk_op !== 2'b00) begin
            errors++;
            $display("FAIL soft_drop req %b op %0d expected 1 0", chk_req, chk_op);
        end
    endtask

    task automatic test_key_overwrite();
        int n;
        do_reset();
        wait_req(20, n);
        key_valid = 1'b1;
        key_code  = 8'h6B;
        step();
        key_valid = 1'b0;
        step();
        key_valid = 1'b1;
        key_code  = 8'h74;
        step();
        key_valid = 1'b0;
        checks++;
        if (chk_req !== 1'b1 || chk_op !== 2'b00) begin
            errors++;
            $display("FAIL keys_in_check req %b op %0d expected 1 0", chk_req, chk_op);
        end
        ack(1'b1);
        step();
        checks++;
        if (chk_req !== 1'b1 || chk_op !== 2'b10) begin
            errors++;
            $display("FAIL latest_key req %b op %0d expected 1 2", chk_req, chk_op);
        end
        ack(1'b1);
        wait_req(20, n);
        checks++;
        if (n !== 2 || chk_op !== 2'b00) begin
            errors++;
            $display("FAIL left_discarded delay %0d op %0d expected 2 0", n, chk_op);
        end
        ack(1'b1);
    endtask

    task automatic test_gravity_key_tie();
        do_reset();
        repeat (7) step();
        key_valid = 1'b1;
        key_code  = 8'h75;
        step();
        key_valid = 1'b0;
        checks++;
        if (chk_req !== 1'b0) begin
            errors++;
            $display("FAIL tie_setup req %b expected 0", chk_req);
        end
        step();
        checks++;
        if (chk_req !== 1'b1 || chk_op !== 2'b00) begin
            errors++;
            $display("FAIL tie_gravity_first req %b op %0d expected 1 0", chk_req, chk_op);
        end
        ack(1'b1);
        step();
        checks++;
        if (chk_req !== 1'b1 || chk_op !== 2'b11) begin
            errors++;
            $display("FAIL tie_rotate_second req %b op %0d expected 1 3", chk_req, chk_op);
        end
        ack(1'b1);
    endtask

    task automatic test_lock_scan();
        int n;
        do_reset();
        full_mask = 16'hC000;
        wait_req(20, n);
        ack(1'b0);
        checks++;
        if (lock !== 1'b1 || chk_req !== 1'b0 || commit !== 1'b0 || state_dbg !== ST_LOCK) begin
            errors++;
            $display("FAIL lock_pulse lock %b req %b commit %b state %0d expected 1 0 0 %0d",
                     lock, chk_req, commit, state_dbg, ST_LOCK);
        end
        step();
        checks++;
        if (lock !== 1'b0 || row_sel !== 4'd15) begin
            errors++;
            $display("FAIL scan_start lock %b row %0d expected 0 15", lock, row_sel);
        end
        step();
        checks++;
        if (shift_req !== 1'b1 || shift_row !== 4'd15) begin
            errors++;
            $display("FAIL shift1 req %b row %0d expected 1 15", shift_req, shift_row);
        end
        step();
        checks++;
        if (shift_req !== 1'b1) begin
            errors++;
            $display("FAIL shift1_held got %b expected 1", shift_req);
        end
        shift_done = 1'b1;
        full_mask  = full_mask << 1;
        step();
        shift_done = 1'b0;
        checks++;
        if (score !== 8'd1 || shift_req !== 1'b0 || row_sel !== 4'd15) begin
            errors++;
            $display("FAIL shift1_done score %0d req %b row %0d expected 1 0 15",
                     score, shift_req, row_sel);
        end
        step();
        checks++;
        if (shift_req !== 1'b1 || shift_row !== 4'd15) begin
            errors++;
            $display("FAIL shift2_rescan req %b row %0d expected 1 15", shift_req, shift_row);
        end
        shift_done = 1'b1;
        full_mask  = full_mask << 1;
        step();
        shift_done = 1'b0;
        wait_spawn(40, n);
        checks++;
        if (n !== 16 || score !== 8'd2 || row_sel !== 4'd1) begin
            errors++;
            $display("FAIL scan_to_spawn steps %0d score %0d row %0d expected 16 2 1",
                     n, score, row_sel);
        end
    endtask

    // Continues from the state test_lock_scan leaves (score 2, just spawned).
    task automatic test_speedup_and_over();
        int n;
        int t[3];
        int bad;
        full_mask = 16'h8000;
        wait_req(40, n);
        ack(1'b0);
        n = 0;
        while (shift_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        shift_done = 1'b1;
        full_mask  = full_mask << 1;
        step();
        shift_done = 1'b0;
        checks++;
        if (score !== 8'd3) begin
            errors++;
            $display("FAIL third_row score %0d expected 3", score);
        end
        wait_spawn(40, n);
        wait_req(20, n);
        ack(1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_req(20, n);
            t[k] = cyc;
            ack(1'b1);
        end
        checks++;
        if (t[1] - t[0] !== 4 || t[2] - t[1] !== 4) begin
            errors++;
            $display("FAIL fast_spacing got %0d %0d expected 4 4", t[1] - t[0], t[2] - t[1]);
        end

        top_occupied = 1'b1;
        wait_req(20, n);
        ack(1'b0);
        n = 0;
        while (game_over !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (game_over !== 1'b1 || state_dbg !== ST_OVER || score !== 8'd3 || spawn !== 1'b0) begin
            errors++;
            $display("FAIL game_over over %b state %0d score %0d spawn %b expected 1 %0d 3 0",
                     game_over, state_dbg, score, spawn, ST_OVER);
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            key_valid = (i % 5 == 0);
            key_code  = (i % 10 == 0) ? 8'h75 : 8'h6B;
            step();
            if (chk_req || spawn || commit || lock || shift_req) bad++;
        end
        key_valid = 1'b0;
        checks++;
        if (bad !== 0 || score !== 8'd3 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL over_absorbing activity %0d score %0d over %b expected 0 3 1",
                     bad, score, game_over);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (score !== 8'd0 || game_over !== 1'b0 || state_dbg !== ST_SPAWN) begin
            errors++;
            $display("FAIL over_reset score %0d over %b state %0d expected 0 0 0",
                     score, game_over, state_dbg);
        end
        top_occupied = 1'b0;
        step();
        resetn = 1'b1;
        step();
        checks++;
        if (spawn !== 1'b1) begin
            errors++;
            $display("FAIL respawn_after_reset got %b expected 1", spawn);
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        wait_req(20, n);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (chk_req !== 1'b0 || state_dbg !== ST_SPAWN) begin
            errors++;
            $display("FAIL async_chk_drop req %b state %0d expected 0 0", chk_req, state_dbg);
        end
        do_reset();
        full_mask = 16'h8000;
        wait_req(20, n);
        ack(1'b0);
        step();
        step();
        checks++;
        if (shift_req !== 1'b1) begin
            errors++;
            $display("FAIL async_shift_setup got %b expected 1", shift_req);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (shift_req !== 1'b0 || row_sel !== 4'd15) begin
            errors++;
            $display("FAIL async_shift_drop req %b row %0d expected 0 15", shift_req, row_sel);
        end
        step();
        resetn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_gravity();
        test_unknown_and_soft_drop();
        test_key_overwrite();
        test_gravity_key_tie();
        test_lock_scan();
        test_speedup_and_over();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_step_sequencer.md
Name: game_step_sequencer

Overview:
- Central game-flow controller for the 16x16 falling-block playfield.
- Owns the gravity timebase and a single-entry keyboard command register.
- Sequences each move through the external collision-check datapath: move/rotate, then lock, then full-row scan, then row shift, then spawn.
- Owns the score register and the game-over state; the board RAM, piece geometry and VGA renderer stay outside this block.

Parameters:
TICK_SLOW, 12000000, gravity period in clk cycles before speed-up
TICK_FAST, 7000000, gravity period once score >= SPEEDUP_SCORE
SPEEDUP_SCORE, 3, score at which the gravity period switches
ROWS, 16, playfield rows; row 0 is the top row

Ports:
clk  in  1  system clock
resetn  in  1  reset; one clock; asynchronous, active-low
key_valid  in  1  one-cycle pulse; key_code is valid
key_code  in  8  PS/2 make code: 8'h75 rotate, 8'h6B left, 8'h74 right, 8'h72 soft drop
chk_req  out  1  collision-check request, held until chk_ack
chk_op  out  2  00 down, 01 left, 10 right, 11 rotate; stable while chk_req=1
chk_ack  in  1  one-cycle check completion
chk_ok  in  1  move is legal; sampled with chk_ack
commit  out  1  one-cycle pulse: apply the checked move
lock  out  1  one-cycle pulse: write the active piece into the board
row_sel  out  4  row being scanned
row_full  in  1  combinational: row row_sel is all ones
shift_req  out  1  held until shift_done; shift rows 1..shift_row down by one and clear row 0
shift_row  out  4  row to delete
shift_done  in  1  one-cycle shift completion
spawn  out  1  one-cycle pulse: new piece at the top
top_occupied  in  1  spawn area of row 0 is occupied
score  out  8  rows cleared, saturating at 99
game_over  out  1  sticky game-over flag

Behaviour:
- Reset values: all outputs 0; row_sel = ROWS-1; tick counter 0; pending key empty; state SPAWN.
- States: SPAWN, WAIT, CHECK, LOCK, SCAN, SHIFT, OVER.
- Tick counter:
  - Runs in every state except OVER.
  - Period P = TICK_FAST when score >= SPEEDUP_SCORE, otherwise TICK_SLOW.
  - At count P-1: wraps to 0 and sets grav_pend.
  - Cleared to 0 on spawn.
- Key register:
  - Holds at most one decoded op.
  - A new valid code overwrites any pending op (latest wins).
  - Unknown codes are ignored.
  - Soft drop decodes to op 00.
  - Keys are ignored in OVER.
- SPAWN:
  - top_occupied=1 → OVER, game_over=1.
  - Otherwise spawn pulse for 1 cycle → WAIT.
- WAIT:
  - grav_pend set → CHECK with op 00; clear grav_pend.
  - Else a pending key → CHECK with that op; clear the key.
  - Gravity wins a same-cycle tie; the key stays pending.
- CHECK:
  - chk_req=1 from the first CHECK cycle.
  - On chk_ack with chk_ok=1: commit pulse in the next cycle → WAIT.
  - chk_ok=0 with op 00 → LOCK.
  - chk_ok=0 with any other op → WAIT, no commit.
- LOCK: lock pulse for 1 cycle; row_sel = ROWS-1 → SCAN.
- SCAN: samples row_full each cycle.
  - row_full=1 → SHIFT with shift_row = row_sel.
  - row_full=0 and row_sel > 1 → decrement row_sel.
  - row_full=0 and row_sel = 1 → SPAWN.
  - Row 0 is never scanned.
- SHIFT:
  - shift_req is held until shift_done.
  - On shift_done: score increments (saturates at 99) → SCAN at the same row_sel, because the contents above have moved down.
- Latency: gravity tick to chk_req = 1 cycle; chk_ack to commit = 1 cycle.
- A key arriving during CHECK, LOCK, SCAN or SHIFT is latched and served on the next WAIT.
- OVER: absorbing until resetn; all pulses and requests stay 0; score holds.
- Asynchronous reset mid-handshake drops chk_req and shift_req immediately.

Test Plan:
- TICK_SLOW=8, no keys, chk_ok=1 → first spawn at cycle 1; chk_req with op 00 every 8 cycles; commit exactly 1 cycle after each chk_ack.
- key 8'h6B then 8'h74 within 2 cycles while in CHECK → one CHECK with op 10 only; 8'h6B is discarded.
- Tick and key 8'h75 in the same WAIT cycle → op 00 is checked first, then op 11 on return to WAIT.
- Down check with chk_ok=0, row_full high for rows 15 and 14 only → lock; SHIFT at row 15 twice (the shifted row 14 is rescanned at 15); scan 14..1; spawn; score=2.
- score reaches 3 with TICK_FAST=4 → tick spacing changes from 8 to 4 cycles.
- top_occupied=1 at spawn → game_over=1; further keys and ticks produce no chk_req; resetn low restores score 0 and a spawn pulse.
